// File: rtl/exec_int_unit.sv
// Integer execution stage: single-cycle ALU/jump, iterative shift-add
// multiplier, branch resolution with a kill-mask pulse, and a held
// valid/ready writeback port toward the physical register file.
module exec_int_unit #(
  parameter int W_WORD     = 32,
  parameter int W_PREG     = 6,
  parameter int W_CTX      = 4,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              order,
  output logic              accepted,
  input  logic [1:0]        i_op,
  input  logic [2:0]        i_func3,
  input  logic [6:0]        i_func7,
  input  logic [W_WORD-1:0] i_d_rs1,
  input  logic [W_WORD-1:0] i_d_rs2,
  input  logic [W_WORD-1:0] i_d_imm,
  input  logic              i_rd_en,
  input  logic [W_PREG-1:0] i_pa_rd,
  input  logic [W_CTX-1:0]  i_context,
  input  logic [W_CTX-1:0]  i_b_t_context,
  input  logic [W_CTX-1:0]  i_b_f_context,
  input  logic              flush,
  input  logic [W_CTX-1:0]  flush_ctx,
  output logic              wb_valid,
  output logic [W_PREG-1:0] wb_pa_rd,
  output logic [W_WORD-1:0] wb_data,
  input  logic              wb_ready,
  output logic              branch_hazard,
  output logic [W_CTX-1:0]  hazard_context_info
);

  localparam int W_CNT = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int W_SH  = $clog2(W_WORD);

  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_MUL    = 2'd1;
  localparam logic [1:0] OP_BRANCH = 2'd2;
  localparam logic [1:0] OP_JUMP   = 2'd3;

  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;

  state_t state_reg, state_next;

  logic [W_CTX-1:0]  ctx_reg;
  logic [W_PREG-1:0] pa_rd_reg;
  logic [W_WORD-1:0] data_reg;
  logic [W_WORD-1:0] mcand_reg;
  logic [W_WORD-1:0] mplier_reg;
  logic [W_CNT-1:0]  cnt_reg;
  logic              rd_en_reg;
  logic              hazard_reg;
  logic [W_CTX-1:0]  hazard_ctx_reg;

  logic              kill_q;
  logic              kill_in;
  logic              mul_last;
  logic [W_WORD-1:0] alu_result;
  logic              br_taken;
  logic [W_SH-1:0]   shamt;
  logic              unused_bits;

  // Only func7[5] selects sub/sra; the remaining bits are deliberately ignored.
  assign unused_bits = ^{i_func7[6], i_func7[4:0]};

  assign kill_q   = flush & (|(flush_ctx & ctx_reg));
  assign kill_in  = flush & (|(flush_ctx & i_context));
  assign mul_last = (cnt_reg == W_CNT'(MUL_CYCLES - 1));
  assign shamt    = i_d_rs2[W_SH-1:0];

  assign wb_valid            = (state_reg == WB) & ~kill_q;
  assign wb_pa_rd            = pa_rd_reg;
  assign wb_data             = data_reg;
  assign branch_hazard       = hazard_reg;
  assign hazard_context_info = hazard_ctx_reg;

  // Single-cycle ALU result; a jump simply writes back its link value.
  always_comb begin
    alu_result = '0;
    unique case (i_func3)
      3'b000: alu_result = i_func7[5] ? (i_d_rs1 - i_d_rs2) : (i_d_rs1 + i_d_rs2);
      3'b001: alu_result = i_d_rs1 << shamt;
      3'b010: alu_result = {{(W_WORD-1){1'b0}}, ($signed(i_d_rs1) < $signed(i_d_rs2))};
      3'b011: alu_result = {{(W_WORD-1){1'b0}}, (i_d_rs1 < i_d_rs2)};
      3'b100: alu_result = i_d_rs1 ^ i_d_rs2;
      3'b101: alu_result = i_func7[5] ? W_WORD'($signed(i_d_rs1) >>> shamt)
                                      : (i_d_rs1 >> shamt);
      3'b110: alu_result = i_d_rs1 | i_d_rs2;
      3'b111: alu_result = i_d_rs1 & i_d_rs2;
    endcase
    if (i_op == OP_JUMP) alu_result = i_d_imm;
  end

  // Branch condition; funct3 010/011 are not branch encodings and never take.
  always_comb begin
    br_taken = 1'b0;
    case (i_func3)
      3'b000:  br_taken = (i_d_rs1 == i_d_rs2);
      3'b001:  br_taken = (i_d_rs1 != i_d_rs2);
      3'b100:  br_taken = ($signed(i_d_rs1) <  $signed(i_d_rs2));
      3'b101:  br_taken = ($signed(i_d_rs1) >= $signed(i_d_rs2));
      3'b110:  br_taken = (i_d_rs1 <  i_d_rs2);
      3'b111:  br_taken = (i_d_rs1 >= i_d_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  // Next state and accept decision; a killed or finished slot can reload directly.
  always_comb begin
    state_next = state_reg;
    accepted   = 1'b0;
    case (state_reg)
      IDLE: accepted = order;
      MUL: begin
        if (kill_q)        state_next = IDLE;
        else if (mul_last) state_next = rd_en_reg ? WB : IDLE;
      end
      WB: begin
        accepted = order & (wb_ready | kill_q);
        if (wb_ready | kill_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accepted) begin
      if (kill_in) begin
        state_next = IDLE;
      end else begin
        case (i_op)
          OP_MUL:    state_next = MUL;
          OP_BRANCH: state_next = IDLE;
          default:   state_next = i_rd_en ? WB : IDLE;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath: capture on accept, iterate the multiplier, emit the branch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_reg        <= '0;
      pa_rd_reg      <= '0;
      data_reg       <= '0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      cnt_reg        <= '0;
      rd_en_reg      <= 1'b0;
      hazard_reg     <= 1'b0;
      hazard_ctx_reg <= '0;
    end else begin
      hazard_reg     <= 1'b0;
      hazard_ctx_reg <= '0;
      if (accepted) begin
        if (!kill_in) begin
          ctx_reg   <= i_context;
          pa_rd_reg <= i_pa_rd;
          rd_en_reg <= i_rd_en;
          case (i_op)
            OP_MUL: begin
              data_reg   <= '0;
              mcand_reg  <= i_d_rs1;
              mplier_reg <= i_d_rs2;
              cnt_reg    <= '0;
            end
            OP_BRANCH: begin
              hazard_reg     <= 1'b1;
              hazard_ctx_reg <= br_taken ? i_b_f_context : i_b_t_context;
            end
            default: data_reg <= alu_result;
          endcase
        end
      end else if (state_reg == MUL) begin
        // data_reg doubles as the product accumulator until writeback.
        if (mplier_reg[0]) data_reg <= data_reg + mcand_reg;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + W_CNT'(1);
      end
    end
  end

endmodule

// File: tb/tb_exec_int_unit.sv
// Self-checking bench for exec_int_unit: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_exec_int_unit;

  localparam int LAT_MUL = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        order;
  logic        accepted;
  logic [1:0]  i_op;
  logic [2:0]  i_func3;
  logic [6:0]  i_func7;
  logic [31:0] i_d_rs1, i_d_rs2, i_d_imm;
  logic        i_rd_en;
  logic [5:0]  i_pa_rd;
  logic [3:0]  i_context, i_b_t_context, i_b_f_context;
  logic        flush;
  logic [3:0]  flush_ctx;
  logic        wb_valid;
  logic [5:0]  wb_pa_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        branch_hazard;
  logic [3:0]  hazard_context_info;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  exec_int_unit dut (
    .clk(clk), .rst(rst), .order(order), .accepted(accepted),
    .i_op(i_op), .i_func3(i_func3), .i_func7(i_func7),
    .i_d_rs1(i_d_rs1), .i_d_rs2(i_d_rs2), .i_d_imm(i_d_imm),
    .i_rd_en(i_rd_en), .i_pa_rd(i_pa_rd), .i_context(i_context),
    .i_b_t_context(i_b_t_context), .i_b_f_context(i_b_f_context),
    .flush(flush), .flush_ctx(flush_ctx),
    .wb_valid(wb_valid), .wb_pa_rd(wb_pa_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .branch_hazard(branch_hazard), .hazard_context_info(hazard_context_info)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: what the instruction should write back.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] imm);
    int sa = a;
    int sb = b;
    longint unsigned prod;
    logic [31:0] r = 0;
    if (op == 2'd3) return imm;
    if (op == 2'd1) begin
      prod = longint'(a) * longint'(b);
      return prod[31:0];
    end
    case (f3)
      3'd0: r = f7[5] ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic rd_en, input logic [5:0] pa, input logic [3:0] ctx,
                           input logic [3:0] bt, input logic [3:0] bf);
    i_op = op; i_func3 = f3; i_func7 = f7; i_d_rs1 = a; i_d_rs2 = b; i_d_imm = imm;
    i_rd_en = rd_en; i_pa_rd = pa; i_context = ctx; i_b_t_context = bt; i_b_f_context = bf;
  endtask

  // Watch n cycles and report whether wb_valid was ever seen.
  task automatic watch_no_wb(input string tag, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wb_valid) seen = 1;
      tick();
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  // Issue one instruction from IDLE and check its complete outcome.
  task automatic run_instr(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic rd_en, input logic [5:0] pa, input logic [3:0] ctx,
                           input logic [3:0] bt, input logic [3:0] bf);
    logic [31:0] exp_d;
    int n, k, lat;
    bit found;
    n_txn++;
    exp_d = model_result(op, f3, f7, a, b, imm);
    $display("txn %0d op=%0d f3=%0d f7=%02h rs1=%08h rs2=%08h rd_en=%0d pa=%0d exp=%08h",
             n_txn, op, f3, f7, a, b, rd_en, pa, exp_d);
    set_instr(op, f3, f7, a, b, imm, rd_en, pa, ctx, bt, bf);
    order = 1; wb_ready = 0;
    @(negedge clk);
    check("accept", 32'(accepted), 32'd1);
    tick();
    order = 0;
    if (op == 2'd2) begin
      @(negedge clk);
      check("br_pulse", 32'(branch_hazard), 32'd1);
      check("br_info", 32'(hazard_context_info), 32'(model_taken(f3, a, b) ? bf : bt));
      check("br_no_wb", 32'(wb_valid), 32'd0);
      tick();
      @(negedge clk);
      check("br_pulse_end", 32'(branch_hazard), 32'd0);
      tick();
      return;
    end
    lat = (op == 2'd1) ? LAT_MUL : 1;
    found = 0; n = 0;
    while (!found && n < 45) begin
      n++;
      @(negedge clk);
      if (wb_valid) found = 1;
      else tick();
    end
    check("wb_seen", 32'(found), 32'(rd_en));
    if (!found) return;
    check("wb_latency", n, lat);
    check("wb_pa", 32'(wb_pa_rd), 32'(pa));
    check("wb_data", wb_data, exp_d);
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      tick();
      @(negedge clk);
      check("wb_hold_v", 32'(wb_valid), 32'd1);
      check("wb_hold_d", wb_data, exp_d);
    end
    wb_ready = 1;
    tick();
    wb_ready = 0;
    @(negedge clk);
    check("wb_done", 32'(wb_valid), 32'd0);
    tick();
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    bit acc_seen;
    bit found;
    int n;

    rst = 1; order = 0; wb_ready = 0; flush = 0; flush_ctx = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    tick(); tick();
    @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_accepted", 32'(accepted), 32'd0);
    check("rst_hazard", 32'(branch_hazard), 32'd0);
    check("rst_info", 32'(hazard_context_info), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_pa", 32'(wb_pa_rd), 32'd0);
    tick();
    rst = 0;
    tick();

    // ALU add with wb_ready already high: latency one, then idle.
    set_instr(0, 3'd0, 7'h00, 32'd5, 32'd7, 0, 1, 6'd9, 4'b0001, 0, 0);
    order = 1; wb_ready = 1;
    @(negedge clk);
    check("add_accept", 32'(accepted), 32'd1);
    tick();
    order = 0;
    @(negedge clk);
    check("add_wb_valid", 32'(wb_valid), 32'd1);
    check("add_wb_pa", 32'(wb_pa_rd), 32'd9);
    check("add_wb_data", wb_data, 32'd12);
    tick();
    @(negedge clk);
    check("add_idle", 32'(wb_valid), 32'd0);
    tick();
    wb_ready = 0;

    // Backpressure on sub 3-5, then back-to-back and 0xF0 & 0x3C.
    set_instr(0, 3'd0, 7'h20, 32'd3, 32'd5, 0, 1, 6'd3, 4'b0001, 0, 0);
    order = 1;
    @(negedge clk);
    check("sub_accept", 32'(accepted), 32'd1);
    tick();
    set_instr(0, 3'd7, 7'h00, 32'hF0, 32'h3C, 0, 1, 6'd4, 4'b0001, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(wb_valid), 32'd1);
      check("bp_data", wb_data, 32'hFFFF_FFFE);
      check("bp_pa", 32'(wb_pa_rd), 32'd3);
      check("bp_accepted", 32'(accepted), 32'd0);
      tick();
    end
    wb_ready = 1;
    @(negedge clk);
    check("b2b_accept", 32'(accepted), 32'd1);
    tick();
    order = 0;
    @(negedge clk);
    check("b2b_valid", 32'(wb_valid), 32'd1);
    check("b2b_data", wb_data, 32'h30);
    check("b2b_pa", 32'(wb_pa_rd), 32'd4);
    tick();
    wb_ready = 0;
    @(negedge clk);
    check("b2b_idle", 32'(wb_valid), 32'd0);
    tick();

    // MUL: exact latency, accepted stays low while another order waits.
    set_instr(1, 3'd0, 7'h00, 32'h1234_5678, 32'h10, 0, 1, 6'd17, 4'b0001, 0, 0);
    order = 1;
    @(negedge clk);
    check("mul_accept", 32'(accepted), 32'd1);
    tick();
    set_instr(0, 3'd0, 7'h00, 32'd1, 32'd1, 0, 1, 6'd5, 4'b0001, 0, 0);
    acc_seen = 0; found = 0; n = 0;
    while (!found && n < 60) begin
      n++;
      @(negedge clk);
      if (accepted) acc_seen = 1;
      if (wb_valid) found = 1;
      else tick();
    end
    check("mul_found", 32'(found), 32'd1);
    check("mul_latency", n, LAT_MUL);
    check("mul_busy", 32'(acc_seen), 32'd0);
    check("mul_data", wb_data, 32'h2345_6780);
    check("mul_pa", 32'(wb_pa_rd), 32'd17);
    order = 0; wb_ready = 1;
    tick();
    wb_ready = 0;
    @(negedge clk);
    check("mul_idle", 32'(wb_valid), 32'd0);
    tick();

    // Branches: signed vs unsigned compare pick opposite kill masks.
    run_instr(2, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 4'b0001, 4'b0010, 4'b0100);
    run_instr(2, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 4'b0001, 4'b0010, 4'b0100);

    // Matching flush at cycle 10 of a multiply abandons it.
    set_instr(1, 3'd0, 7'h00, 32'd1000, 32'd3, 0, 1, 6'd8, 4'b0010, 0, 0);
    order = 1;
    @(negedge clk);
    check("fmul_accept", 32'(accepted), 32'd1);
    tick();
    order = 0;
    repeat (9) tick();
    flush = 1; flush_ctx = 4'b0010;
    @(negedge clk);
    check("fmul_wb", 32'(wb_valid), 32'd0);
    tick();
    flush = 0; flush_ctx = 0;
    run_instr(2, 3'd0, 7'h00, 32'd1, 32'd1, 0, 0, 0, 4'b0001, 4'b0001, 4'b1000);
    watch_no_wb("fmul_no_wb", 40);

    // Non-matching flush during WB leaves the write intact.
    set_instr(0, 3'd6, 7'h00, 32'hA0, 32'h0B, 0, 1, 6'd11, 4'b0010, 0, 0);
    order = 1;
    tick();
    order = 0; flush = 1; flush_ctx = 4'b0001;
    @(negedge clk);
    check("nflush_valid", 32'(wb_valid), 32'd1);
    check("nflush_data", wb_data, 32'hAB);
    tick();
    flush = 0; flush_ctx = 0; wb_ready = 1;
    @(negedge clk);
    check("nflush_still", 32'(wb_valid), 32'd1);
    tick();
    wb_ready = 0;

    // Matching flush together with wb_ready: no write.
    set_instr(0, 3'd0, 7'h00, 32'd1, 32'd2, 0, 1, 6'd12, 4'b0100, 0, 0);
    order = 1;
    tick();
    order = 0; flush = 1; flush_ctx = 4'b0100; wb_ready = 1;
    @(negedge clk);
    check("fwb_valid", 32'(wb_valid), 32'd0);
    tick();
    flush = 0; flush_ctx = 0; wb_ready = 0;
    watch_no_wb("fwb_after", 3);

    // Killed at accept: consumed, no writeback and no branch pulse.
    set_instr(0, 3'd0, 7'h00, 32'd1, 32'd2, 0, 1, 6'd13, 4'b1000, 0, 0);
    order = 1; flush = 1; flush_ctx = 4'b1000;
    @(negedge clk);
    check("kin_accept", 32'(accepted), 32'd1);
    tick();
    set_instr(2, 3'd0, 7'h00, 32'd1, 32'd1, 0, 0, 0, 4'b1000, 4'b0001, 4'b0010);
    @(negedge clk);
    check("kin_no_wb", 32'(wb_valid), 32'd0);
    check("kin_br_accept", 32'(accepted), 32'd1);
    tick();
    order = 0; flush = 0; flush_ctx = 0;
    @(negedge clk);
    check("kin_no_pulse", 32'(branch_hazard), 32'd0);
    tick();

    // Asynchronous reset in the middle of a multiply.
    set_instr(1, 3'd0, 7'h00, 32'h0000_FFFF, 32'h0000_00FF, 0, 1, 6'h2A, 4'b0001, 0, 0);
    order = 1;
    tick();
    order = 0;
    repeat (4) tick();
    rst = 1;
    #1;
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    check("arst_wb_pa", 32'(wb_pa_rd), 32'd0);
    check("arst_hazard", 32'(branch_hazard), 32'd0);
    check("arst_accepted", 32'(accepted), 32'd0);
    tick();
    rst = 0;
    watch_no_wb("arst_no_wb", 40);
    run_instr(0, 3'd4, 7'h00, 32'h55, 32'hFF, 0, 1, 6'd7, 4'b0001, 0, 0);

    // Randomized instruction stream.
    for (int t = 0; t < 120; t++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      run_instr(op, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                rnd_word(), rnd_word(), $urandom, 1'($urandom_range(0, 3) != 0),
                6'($urandom), 4'b0001 << $urandom_range(0, 3),
                4'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_int_unit.md
Name: exec_int_unit

Overview:
- Integer execution stage directly downstream of the instruction window.
- Takes one ready instruction per handshake (order/accepted) with operands already resolved. Executes ALU, MUL, branch or jump.
- Writes the result to the physical register file via a valid/ready port. Reports branch outcomes to the context manager as a hazard pulse carrying the contexts to kill.

Parameters:
- W_WORD, 32, data width
- W_PREG, 6, physical register address width
- W_CTX, 4, one-hot context mask width
- MUL_CYCLES, 32, iterations of the shift-add multiplier (equals W_WORD)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- order  in  1  window offers an instruction this cycle
- accepted  out  1  instruction taken this cycle (combinational)
- i_op  in  2  0=ALU, 1=MUL, 2=BRANCH, 3=JUMP
- i_func3  in  3  RV32I funct3
- i_func7  in  7  RV32I funct7
- i_d_rs1  in  W_WORD  operand 1
- i_d_rs2  in  W_WORD  operand 2 (immediate already substituted by window)
- i_d_imm  in  W_WORD  JUMP: link value
- i_rd_en  in  1  instruction writes rd
- i_pa_rd  in  W_PREG  destination physical register
- i_context  in  W_CTX  context of instruction
- i_b_t_context  in  W_CTX  contexts killed if branch not taken
- i_b_f_context  in  W_CTX  contexts killed if branch taken
- flush  in  1  context manager kill request
- flush_ctx  in  W_CTX  contexts being killed
- wb_valid  out  1  writeback request
- wb_pa_rd  out  W_PREG  writeback address
- wb_data  out  W_WORD  writeback data
- wb_ready  in  1  register file takes writeback
- branch_hazard  out  1  one-cycle branch resolution pulse
- hazard_context_info  out  W_CTX  contexts to kill, valid with branch_hazard

Behaviour:
- States: IDLE, MUL, WB. Reset value is IDLE.
- Reset values: all outputs 0; internal registers 0.
- kill_q = flush & |(flush_ctx & ctx_q), where ctx_q is the latched context. kill_in = flush & |(flush_ctx & i_context).
- accepted = order & (state==IDLE | (state==WB & (wb_ready | kill_q))).
- On accept, the instruction is consumed even if kill_in. If kill_in, no effect and next state is IDLE.
- ALU, registered in the accept cycle:
  - func3 000: add, or sub when func7[5]=1.
  - 001: sll. 010: slt. 011: sltu. 100: xor.
  - 101: srl, or sra when func7[5]=1. Shift amount is rs2[4:0].
  - 110: or. 111: and.
  - If rd_en, next state is WB, with wb_valid in the cycle after accept (latency 1). Otherwise next state is IDLE.
- MUL: low W_WORD bits of rs1*rs2, unsigned shift-add, one bit per cycle. Only func3=000 is defined; other func3 values give the same result.
  - Counter counts 0..MUL_CYCLES-1. After the last iteration the state goes to WB.
  - wb_valid appears MUL_CYCLES+1 cycles after accept.
  - If rd_en=0, the multiply still runs, then the state goes to IDLE without writeback.
- BRANCH: compares rs1 vs rs2. func3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010/011 are never taken.
  - In the cycle after accept: branch_hazard=1 and hazard_context_info = taken ? b_f_context : b_t_context. State goes to IDLE.
  - No writeback. The pulse is suppressed if the branch was killed at accept.
- JUMP: wb_data = i_d_imm, otherwise handled as ALU.
- WB: wb_valid = (state==WB) & ~kill_q.
  - wb_pa_rd and wb_data are held stable until wb_ready.
  - On wb_ready, go to IDLE, or reload directly if accepted the same cycle.
- Flush in MUL or WB with kill_q: abandon, no writeback, go to IDLE (or reload if accepted).
- Flush and wb_ready in the same cycle with kill_q: flush wins, so no write occurs.
- Non-matching flush has no effect.
- Back-to-back: in WB with wb_ready=1 and order=1, the new instruction is accepted and wb_valid stays high with new data the next cycle.
- Asynchronous rst mid-MUL or mid-WB: immediate return to IDLE, outputs 0, no writeback.

Test Plan:
- ALU add: order, i_op=0, func3=0, rs1=5, rs2=7, rd_en=1, pa_rd=9, wb_ready=1. Required: accepted same cycle; next cycle wb_valid=1, wb_pa_rd=9, wb_data=12; then IDLE.
- Backpressure and back-to-back: sub 3-5 with wb_ready=0 for 3 cycles. Required: wb_data=0xFFFFFFFE held stable and accepted=0 throughout. When wb_ready=1 with a second order (and 0xF0, 0x3C), the next cycle gives wb_data=0x30.
- MUL: rs1=0x12345678, rs2=0x10. Required: wb_valid exactly 33 cycles after accept, wb_data=0x23456780; accepted=0 during MUL.
- Branch: blt rs1=-1, rs2=1, b_t=4'b0010, b_f=4'b0100. Required: one-cycle branch_hazard=1 with hazard_context_info=4'b0100. Repeat with bltu: info=4'b0010. No wb_valid in either case.
- Flush: MUL with context 4'b0010; flush=1, flush_ctx=4'b0010 at cycle 10. Required: IDLE next cycle, no writeback. flush_ctx=4'b0001 during WB leaves the write intact. Flush coinciding with wb_ready for a matching context produces no write.
- Reset: assert rst mid-MUL (cycle 5). Required: all outputs 0 immediately; after release, accepted=1 on the next order.
